serial_cla_addsub: RTL and testbench

//  - Digit-serial adder/subtractor that consumes the lookahead carry chain.
//  - Processes one DIGIT-bit slice per clock, LSB first: per-bit generate/propagate,
//    2-bit carry lookahead, sum; the digit carry-out is registered between cycles.
//  - Trades WIDTH/DIGIT cycles of latency for a single DIGIT-wide carry path.

---
 rtl/serial_addsub_pkg.sv | 10 +
 rtl/serial_cla_addsub_cla_digit.sv | 24 ++
 rtl/serial_cla_addsub.sv | 134 +++++++++++++
 tb/tb_serial_cla_addsub.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial carry-lookahead adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} addsub_state_t;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/serial_cla_addsub_cla_digit.sv
// Combinational 2-bit carry-lookahead slice: generate/propagate, lookahead carries, sum.
module cla_digit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout,
    output logic       msb_cin
);

    logic [1:0] g;
    logic [1:0] p;
    logic       c1;

    assign g = a & b;
    assign p = a ^ b;

    // Both carries are flattened so neither waits on a ripple through bit 0.
    assign c1      = g[0] | (p[0] & cin);
    assign cout    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign sum     = p ^ {c1, cin};
    assign msb_cin = c1;

endmodule

// File: rtl/serial_cla_addsub.sv
// Digit-serial add/subtract, LSB digit first, with valid/ready on both sides.
// Optional zero/ovf flags are built when SERIAL_ADDSUB_FLAGS_EN is defined.
module serial_cla_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDSUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int NDIG  = num_digits(WIDTH, DIGIT);
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_width
        $error("serial_cla_addsub: WIDTH must be a multiple of DIGIT");
    end
    if (DIGIT != 2) begin : g_bad_digit
        $error("serial_cla_addsub: DIGIT must be 2");
    end

    addsub_state_t    state;
    addsub_state_t    state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             dmsb_cin;
    logic [WIDTH-1:0] res_nxt;
    logic             accept;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (state == BUSY) && (cnt == LAST);

    // a_sr doubles as the result accumulator: sum digits enter at the top as operand digits leave the bottom.
    assign res_nxt = {dsum, a_sr[WIDTH-1:DIGIT]};

    cla_digit u_digit (
        .a       (a_sr[DIGIT-1:0]),
        .b       (b_sr[DIGIT-1:0]),
        .cin     (carry),
        .sum     (dsum),
        .cout    (dcout),
        .msb_cin (dmsb_cin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr <= a;
            b_sr <= b ^ {WIDTH{sub}};
        end else if (state == BUSY) begin
            a_sr <= res_nxt;
            b_sr <= {{DIGIT{1'b0}}, b_sr[WIDTH-1:DIGIT]};
        end
    end

`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic msb_cin_r;

    assign ovf = msb_cin_r ^ cout;
`else
    logic unused_msb_cin;

    assign unused_msb_cin = dmsb_cin;
`endif

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
            zero      <= 1'b0;
            msb_cin_r <= 1'b0;
`endif
        end else if (accept) begin
            cnt   <= '0;
            carry <= sub;
        end else if (state == BUSY) begin
            cnt   <= cnt + 1'b1;
            carry <= dcout;
            if (last) begin
                sum       <= res_nxt;
                cout      <= dcout;
`ifdef SERIAL_ADDSUB_FLAGS_EN
                zero      <= (res_nxt == '0);
                msb_cin_r <= dmsb_cin;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_cla_addsub.sv
// Directed bench for serial_cla_addsub at WIDTH=8; flag checks follow SERIAL_ADDSUB_FLAGS_EN.
module tb_serial_cla_addsub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic       zero;
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_cla_addsub #(.WIDTH(8), .DIGIT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDSUB_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       z;
        logic       o;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits for in_ready, presents one operation, and counts cycles from the accept edge to out_valid.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tsub, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a = ta;
        b = tb_;
        sub = tsub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h4B, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{8'hC3, 8'h3D, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'h00);
        check("reset_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDSUB_FLAGS_EN
        check("reset_zero", 32'(zero), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back table with out_ready tied high
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].c));
`ifdef SERIAL_ADDSUB_FLAGS_EN
            check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].o));
`endif
        end
        @(posedge clk); #1;
        check("b2b_idle_after", 32'(in_ready), 32'd1);

        // Backpressure: result held, no accept while DONE
        out_ready = 1'b0;
        run_op(8'h5A, 8'h3C, 1'b0, lat);
        check("bp_latency", 32'(lat), 32'd4);
        a = 8'h11;
        b = 8'h22;
        sub = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_sum", k), 32'(sum), 32'h96);
            check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        check("bp_ignored_second_op", 32'(seen), 32'd0);
        check("bp_sum_kept", 32'(sum), 32'h96);

        // Asynchronous reset during BUSY cycle 2
        a = 8'hFF;
        b = 8'hFF;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_valid_pulse", 32'(seen), 32'd0);
        check("midrst_ready_after", 32'(in_ready), 32'd1);
        run_op(8'h01, 8'h02, 1'b0, lat);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_sum", 32'(sum), 32'h03);
        check("post_rst_cout", 32'(cout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
